// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, the NOP encoding and the
// fetch-stage state encoding.
package pipeline_pkg;

  localparam int PIPE_ADDR_W = 10;
  localparam int PIPE_DATA_W = 32;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch stage: drives a 1-cycle synchronous instruction ROM and
// presents one instruction per clock to IF/ID, with stall hold and branch redirect.
module fetch_controller
  import pipeline_pkg::*;
#(
  parameter int ADDR_W   = PIPE_ADDR_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int RESET_PC = 0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [DATA_W-1:0] rom_douta,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);

  localparam logic [ADDR_W-1:0] BOOT_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] hold_pc, hold_pc_nxt;
  logic [DATA_W-1:0] hold_instr, hold_instr_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can infer a latch.
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_pc_nxt   = fetch_pc;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    rom_ena        = 1'b0;
    rom_addra      = pc;
    instr          = NOP_W;
    instr_pc       = fetch_pc;
    instr_valid    = 1'b0;

    case (state)
      BOOT: begin
        // Redirects are ignored until the first real fetch is in flight.
        rom_ena      = 1'b1;
        rom_addra    = BOOT_PC;
        instr_pc     = BOOT_PC;
        pc_nxt       = BOOT_PC + PC_ONE;
        fetch_pc_nxt = BOOT_PC;
        state_nxt    = RUN;
      end
      default: begin
        if (branch_taken) begin
          // The instruction in flight is wrong-path: squash it to a bubble.
          rom_ena      = 1'b1;
          rom_addra    = branch_target;
          pc_nxt       = branch_target + PC_ONE;
          fetch_pc_nxt = branch_target;
          state_nxt    = RUN;
        end else begin
          instr_valid = 1'b1;
          if (state == RUN) begin
            instr    = rom_douta;
            instr_pc = fetch_pc;
          end else begin
            instr    = hold_instr;
            instr_pc = hold_pc;
          end

          if (stall) begin
            // ROM output is only trustworthy for one cycle, so park it locally.
            if (state == RUN) begin
              hold_instr_nxt = rom_douta;
              hold_pc_nxt    = fetch_pc;
            end
            state_nxt = HOLD;
          end else begin
            rom_ena      = 1'b1;
            rom_addra    = pc;
            pc_nxt       = pc + PC_ONE;
            fetch_pc_nxt = pc;
            state_nxt    = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clka) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= BOOT_PC;
      fetch_pc   <= BOOT_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_pc   <= fetch_pc_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: synchronous ROM model, stream-level reference
// model checked every cycle, directed literal scenarios, then random traffic.
module tb_fetch_controller;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          rom_ena;
  logic [AW-1:0] rom_addra;
  logic [DW-1:0] rom_douta = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;

  int tests = 0;
  int fails = 0;

  always #5 clka = ~clka;

  fetch_controller #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(0)
  ) dut (
    .clka         (clka),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rom_ena      (rom_ena),
    .rom_addra    (rom_addra),
    .rom_douta    (rom_douta),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid)
  );

  // Instruction memory: 1-cycle synchronous read, output held while disabled.
  always @(posedge clka)
    if (rom_ena) rom_douta <= 32'hA000_0000 + {22'd0, rom_addra};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stream-level model: either a boot bubble is due, or address m_cur is the
  // instruction the stage owns this cycle.
  bit            m_live = 1'b0;
  bit            m_boot = 1'b1;
  logic [AW-1:0] m_cur  = '0;

  always @(posedge clka) begin
    if (!rst_n) begin
      m_live <= 1'b1;
      m_boot <= 1'b1;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_cur  <= '0;
    end else if (branch_taken) begin
      m_cur <= branch_target;
    end else if (!stall) begin
      m_cur <= m_cur + 10'd1;
    end
  end

  logic          e_valid, e_ena;
  logic [AW-1:0] e_pc, e_addr;
  logic [DW-1:0] e_instr;

  always @(negedge clka) begin
    if (m_live) begin
      if (m_boot) begin
        e_valid = 1'b0; e_pc = '0; e_instr = '0; e_ena = 1'b1; e_addr = '0;
      end else if (branch_taken) begin
        e_valid = 1'b0; e_pc = m_cur; e_instr = '0; e_ena = 1'b1; e_addr = branch_target;
      end else begin
        e_valid = 1'b1; e_pc = m_cur; e_instr = 32'hA000_0000 + {22'd0, m_cur};
        e_ena = !stall; e_addr = m_cur + 10'd1;
      end
      check("model_valid", 32'(instr_valid), 32'(e_valid));
      check("model_pc", 32'(instr_pc), 32'(e_pc));
      check("model_instr", instr, e_instr);
      check("model_ena", 32'(rom_ena), 32'(e_ena));
      if (e_ena) check("model_addr", 32'(rom_addra), 32'(e_addr));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b, input logic [AW-1:0] t);
    @(posedge clka);
    #1;
    rst_n = r; stall = s; branch_taken = b; branch_target = t;
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [AW-1:0] t,
                      input string name, input logic ev, input logic [AW-1:0] epc,
                      input logic [DW-1:0] ei, input logic eena);
    cyc(r, s, b, t);
    @(negedge clka);
    check({name, "_valid"}, 32'(instr_valid), 32'(ev));
    check({name, "_pc"}, 32'(instr_pc), 32'(epc));
    check({name, "_instr"}, instr, ei);
    check({name, "_ena"}, 32'(rom_ena), 32'(eena));
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // Reset release and straight-line fetch.
    step(1, 0, 0, 0, "boot", 0, 0, 32'h0, 1);
    step(1, 0, 0, 0, "run0", 1, 0, 32'hA000_0000, 1);
    step(1, 0, 0, 0, "run1", 1, 1, 32'hA000_0001, 1);
    step(1, 0, 0, 0, "run2", 1, 2, 32'hA000_0002, 1);
    step(1, 0, 0, 0, "run3", 1, 3, 32'hA000_0003, 1);
    step(1, 0, 0, 0, "run4", 1, 4, 32'hA000_0004, 1);
    // Three stall cycles on pc 5.
    step(1, 1, 0, 0, "stall5a", 1, 5, 32'hA000_0005, 0);
    step(1, 1, 0, 0, "stall5b", 1, 5, 32'hA000_0005, 0);
    step(1, 1, 0, 0, "stall5c", 1, 5, 32'hA000_0005, 0);
    step(1, 0, 0, 0, "stall5d", 1, 5, 32'hA000_0005, 1);
    step(1, 0, 0, 0, "run6", 1, 6, 32'hA000_0006, 1);
    // Branch to 40 while presenting 7.
    step(1, 0, 1, 40, "br_bubble", 0, 7, 32'h0, 1);
    step(1, 0, 0, 0, "br40", 1, 40, 32'hA000_0028, 1);
    step(1, 0, 0, 0, "br41", 1, 41, 32'hA000_0029, 1);
    // Branch with stall, stall held one more cycle.
    step(1, 1, 1, 100, "bs_bubble", 0, 42, 32'h0, 1);
    step(1, 1, 0, 0, "bs100a", 1, 100, 32'hA000_0064, 0);
    step(1, 0, 0, 0, "bs100b", 1, 100, 32'hA000_0064, 1);
    step(1, 0, 0, 0, "bs101", 1, 101, 32'hA000_0065, 1);
    // Address wrap.
    step(1, 0, 1, 1022, "wrap_bubble", 0, 102, 32'h0, 1);
    step(1, 0, 0, 0, "wrap1022", 1, 1022, 32'hA000_03FE, 1);
    step(1, 0, 0, 0, "wrap1023", 1, 1023, 32'hA000_03FF, 1);
    step(1, 0, 0, 0, "wrap0", 1, 0, 32'hA000_0000, 1);
    step(1, 0, 0, 0, "wrap1", 1, 1, 32'hA000_0001, 1);
    // Reset during HOLD discards the held instruction.
    step(1, 1, 0, 0, "hold2a", 1, 2, 32'hA000_0002, 0);
    step(0, 1, 0, 0, "hold2b", 1, 2, 32'hA000_0002, 0);
    step(1, 0, 0, 0, "rst_boot", 0, 0, 32'h0, 1);
    step(1, 0, 0, 0, "rst0", 1, 0, 32'hA000_0000, 1);
    step(1, 0, 0, 0, "rst1", 1, 1, 32'hA000_0001, 1);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic          r, s, b;
      logic [AW-1:0] t;
      r = ($urandom_range(99) != 0);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 12);
      t = ($urandom_range(3) == 0) ? 10'h3FF : 10'($urandom);
      cyc(r, s, b, t);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    @(negedge clka);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first word fetched after reset.
REQ-004 clka  input  1  single clock for the block, rising-edge active.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clka.
REQ-006 stall  input  1  downstream IF/ID not accepting; hold the presented instruction.
REQ-007 branch_taken  input  1  redirect request from a later stage.
REQ-008 branch_target  input  ADDR_W  redirect word address, valid when branch_taken=1.
REQ-009 rom_ena  output  1  InstructionMemory read enable.
REQ-010 rom_addra  output  ADDR_W  InstructionMemory read address.
REQ-011 rom_douta  input  DATA_W  InstructionMemory data, valid one clka after the address is issued with rom_ena=1.
REQ-012 instr  output  DATA_W  instruction presented to IF/ID.
REQ-013 instr_pc  output  ADDR_W  word address of instr.
REQ-014 instr_valid  output  1  instr/instr_pc are a live instruction.

Function
REQ-015 The block SHALL implement states BOOT, RUN and HOLD.
REQ-016 Internal registers SHALL be: pc (next address to issue), fetch_pc (address issued last cycle), hold_instr, hold_pc.
REQ-017 BOOT: rom_ena=1, rom_addra=RESET_PC, instr_valid=0; next cycle pc=RESET_PC+1, fetch_pc=RESET_PC, state RUN.
REQ-018 RUN, no branch, no stall: instr=rom_douta, instr_pc=fetch_pc, instr_valid=1, rom_ena=1, rom_addra=pc; next pc=pc+1, fetch_pc=pc.
REQ-019 RUN, stall=1, branch_taken=0: instr_valid=1 with current ROM data, rom_ena=0; hold_instr=rom_douta, hold_pc=fetch_pc captured; pc unchanged; next state HOLD.
REQ-020 HOLD: instr=hold_instr, instr_pc=hold_pc, instr_valid=1; rom_ena=0 while stall=1; state unchanged.
REQ-021 HOLD, stall=0, branch_taken=0: rom_ena=1, rom_addra=pc; next pc=pc+1, fetch_pc=pc, state RUN.
REQ-022 branch_taken=1 in RUN or HOLD: instr_valid=0 that cycle, rom_ena=1, rom_addra=branch_target; next pc=branch_target+1, fetch_pc=branch_target, state RUN.
REQ-023 branch_taken SHALL have priority over stall; if stall is still 1 the next cycle, REQ-019 applies to the target instruction.
REQ-024 branch_taken in BOOT SHALL be ignored.
REQ-025 pc arithmetic SHALL be modulo 2^ADDR_W; pc 1023 increments to 0, branch_target 1023 yields pc 0.
REQ-026 When instr_valid=0, instr SHALL be 0 (NOP) and instr_pc SHALL be fetch_pc.
REQ-027 Redirect-to-valid latency SHALL be exactly one bubble cycle; steady-state throughput one instruction per clka.

Reset
REQ-028 While rst_n=0 at a rising clka: state=BOOT, pc=RESET_PC, fetch_pc=RESET_PC, hold_instr=0, hold_pc=0.
REQ-029 Outputs in reset/BOOT SHALL be rom_ena=1, rom_addra=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL discard held and in-flight data; no instr_valid=1 until one cycle after BOOT.

Structure
REQ-031 State encoding, ADDR_W/DATA_W defaults and the NOP constant (32'h0) SHALL live in the shared pipeline_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; InstructionMemory is instantiated by the parent, not inside fetch_controller.

Verification
REQ-033 Bench SHALL model InstructionMemory as 1-cycle synchronous ROM with mem[i]=32'hA000_0000+i, holding douta when ena=0.
REQ-034 Reset release, no stall -> instr_valid first high on the 2nd clka after release with instr=32'hA000_0000, instr_pc=0; then 1,2,3 on consecutive cycles.
REQ-035 stall high 3 cycles while instr_pc=5 -> instr=32'hA000_0005, instr_pc=5 held for 4 cycles, rom_ena=0 for 3; then instr_pc=6 follows with no gap.
REQ-036 branch_taken with target 40 while instr_pc=7 -> instr_valid=0 that cycle, next cycle instr_pc=40, instr=32'hA000_0028, then 41.
REQ-037 branch_taken and stall together, target 100, stall held one more cycle -> bubble, then instr_pc=100 held 2 cycles, then 101.
REQ-038 Branch to 1022, no stall -> instr_pc sequence 1022, 1023, 0, 1; rst_n low during a HOLD -> instr_valid=0 next cycle, sequence restarts at 0.
